spi_gcd_cmd_sequencer: RTL and testbench

Command sequencer directly downstream of the SPI slave wrapper. Consumes each received 32-bit SPI word, decodes a command byte, loads GCD operands, runs the GCD engine through an enable/done handshake, and publishes result plus status as the next SPI transmit word. Runs entirely in the system clock domain. Input words arrive already synchronized.

---
 rtl/sobel_gcd_pkg.sv | 21 ++
 rtl/gcd_timeout_counter.sv | 27 ++
 rtl/spi_gcd_cmd_sequencer.sv | 136 +++++++++++++
 tb/tb_spi_gcd_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_gcd_pkg.sv
// Shared definitions for the SPI-driven GCD command sequencer:
// command codes, FSM state encoding and status-bit positions.
package sobel_gcd_pkg;

    localparam logic [7:0] CMD_LOAD_A = 8'h20;
    localparam logic [7:0] CMD_LOAD_B = 8'h21;
    localparam logic [7:0] CMD_START  = 8'h22;
    localparam logic [7:0] CMD_NOP    = 8'h23;
    localparam logic [7:0] CMD_CLEAR  = 8'h24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam int STAT_BUSY  = 31;
    localparam int STAT_DONE  = 30;
    localparam int STAT_ERROR = 29;

endpackage

// File: rtl/gcd_timeout_counter.sv
// Bounded wait counter for the GCD handshake; expired_o flags the
// last allowed cycle. Only instantiated when GCD_TIMEOUT_EN is defined.
module gcd_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    assign expired_o = (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            count <= '0;
        end else if (enable_i && !expired_o) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_gcd_cmd_sequencer.sv
// Decodes SPI command words, sequences the GCD engine and publishes status.
// Optional GCD_TIMEOUT_EN bounds the wait on gcd_done_i.
module spi_gcd_cmd_sequencer
    import sobel_gcd_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [WORD_SIZE-1:0]  rx_word_i,
    input  logic                  rx_valid_i,
    output logic [WORD_SIZE-1:0]  tx_word_o,
    output logic [DATA_WIDTH-1:0] operand_a_o,
    output logic [DATA_WIDTH-1:0] operand_b_o,
    output logic                  gcd_enable_o,
    input  logic [DATA_WIDTH-1:0] gcd_i,
    input  logic                  gcd_done_i,
    output logic                  busy_o,
    output logic                  error_o
);

    state_e state, state_next;

    logic [DATA_WIDTH-1:0] result;
    logic                  done;
    logic                  error;
    logic                  timeout;
    logic                  load_a, load_b, start, reject, clear;
    logic                  eval_zero, capture, timed_out;
    logic [7:0]            cmd;
    logic [WORD_SIZE-1:0]  tx_next;

    assign cmd          = rx_word_i[31:24];
    assign busy_o       = (state != S_IDLE);
    assign gcd_enable_o = (state == S_WAIT);
    assign error_o      = error;

`ifdef GCD_TIMEOUT_EN
    gcd_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (state != S_WAIT),
        .enable_i (state == S_WAIT),
        .expired_o(timeout)
    );
    logic unused_bits;
    assign unused_bits = ^rx_word_i[23:DATA_WIDTH];
`else
    assign timeout = 1'b0;
    logic unused_bits;
    assign unused_bits = ^rx_word_i[23:DATA_WIDTH] ^ (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        start      = 1'b0;
        reject     = 1'b0;
        clear      = 1'b0;
        eval_zero  = 1'b0;
        capture    = 1'b0;
        timed_out  = 1'b0;
        if (rx_valid_i) begin
            case (cmd)
                CMD_LOAD_A: if (busy_o) reject = 1'b1; else load_a = 1'b1;
                CMD_LOAD_B: if (busy_o) reject = 1'b1; else load_b = 1'b1;
                CMD_START:  if (busy_o) reject = 1'b1; else start = 1'b1;
                CMD_CLEAR:  clear = 1'b1;
                default: ;
            endcase
        end
        case (state)
            S_IDLE: if (start) state_next = S_EVAL;
            S_EVAL: begin
                // A zero operand short-circuits the engine: gcd(x,0) = x
                if (operand_a_o == '0 || operand_b_o == '0) begin
                    eval_zero  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (gcd_done_i) begin
                    capture    = 1'b1;
                    state_next = S_IDLE;
                end else if (timeout) begin
                    timed_out  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_next             = '0;
        tx_next[STAT_BUSY]  = busy_o;
        tx_next[STAT_DONE]  = done;
        tx_next[STAT_ERROR] = error;
        tx_next[15:0]       = 16'(result);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            operand_a_o <= '0;
            operand_b_o <= '0;
            result      <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            tx_word_o   <= '0;
        end else begin
            if (load_a) operand_a_o <= rx_word_i[DATA_WIDTH-1:0];
            if (load_b) operand_b_o <= rx_word_i[DATA_WIDTH-1:0];
            if (eval_zero)    result <= operand_a_o | operand_b_o;
            else if (capture) result <= gcd_i;
            // Setting a flag takes priority over a same-cycle clear
            if (eval_zero || capture)  done <= 1'b1;
            else if (clear || start)   done <= 1'b0;
            if (reject || timed_out)   error <= 1'b1;
            else if (clear)            error <= 1'b0;
            tx_word_o <= tx_next;
        end
    end

endmodule

// File: tb/tb_spi_gcd_cmd_sequencer.sv
// Scenario bench for spi_gcd_cmd_sequencer; timeout scenario runs when
// GCD_TIMEOUT_EN is defined.
module tb_spi_gcd_cmd_sequencer;

    localparam logic [7:0] C_LOAD_A = 8'h20;
    localparam logic [7:0] C_LOAD_B = 8'h21;
    localparam logic [7:0] C_START  = 8'h22;
    localparam logic [7:0] C_NOP    = 8'h23;
    localparam logic [7:0] C_CLEAR  = 8'h24;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] rx_word_i = '0;
    logic        rx_valid_i = 1'b0;
    logic [31:0] tx_word_o;
    logic [15:0] operand_a_o, operand_b_o;
    logic        gcd_enable_o;
    logic [15:0] gcd_i = '0;
    logic        gcd_done_i = 1'b0;
    logic        busy_o, error_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    spi_gcd_cmd_sequencer #(
        .DATA_WIDTH(16),
        .WORD_SIZE(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .rx_word_i(rx_word_i),
        .rx_valid_i(rx_valid_i),
        .tx_word_o(tx_word_o),
        .operand_a_o(operand_a_o),
        .operand_b_o(operand_b_o),
        .gcd_enable_o(gcd_enable_o),
        .gcd_i(gcd_i),
        .gcd_done_i(gcd_done_i),
        .busy_o(busy_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] cmd, input logic [15:0] payload);
        rx_word_i  = {cmd, 8'h00, payload};
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        rx_word_i  = '0;
    endtask

    // Stub engine: raises done on the n-th cycle it sees enable high.
    task automatic stub(input int n, input logic [15:0] val,
                        input logic clr_same, output int en, output logic ok);
        en = 0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (gcd_enable_o) begin
                en++;
                if (en == n) begin
                    gcd_done_i = 1'b1;
                    gcd_i      = val;
                    if (clr_same) begin
                        rx_word_i  = {C_CLEAR, 24'h0};
                        rx_valid_i = 1'b1;
                    end
                    ok = 1'b1;
                end
            end
            tick();
        end
        gcd_done_i = 1'b0;
        rx_valid_i = 1'b0;
        rx_word_i  = '0;
    endtask

    task automatic check_tx(input string name);
        logic [31:0] exp;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, tx=%h", name, tx_word_o);
        end else begin
            exp = sb.pop_front();
            if (tx_word_o !== exp) begin
                failures++;
                $display("FAIL %s: tx=%h expected %h", name, tx_word_o, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        checks++;
        if ({gcd_enable_o, busy_o, error_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000",
                     {gcd_enable_o, busy_o, error_o});
        end
        checks++;
        if ({operand_a_o, operand_b_o, tx_word_o} !== 64'h0) begin
            failures++;
            $display("FAIL reset_regs: a=%h b=%h tx=%h expected 0",
                     operand_a_o, operand_b_o, tx_word_o);
        end
    endtask

    task automatic test_gcd_run();
        int en;
        logic ok;
        send(C_LOAD_A, 16'h0030);
        send(C_LOAD_B, 16'h0012);
        checks++;
        if (operand_a_o !== 16'h0030 || operand_b_o !== 16'h0012) begin
            failures++;
            $display("FAIL load_ops: a=%h b=%h expected 0030 0012",
                     operand_a_o, operand_b_o);
        end
        sb.push_back(32'h4000_0006);
        send(C_START, 16'h0);
        checks++;
        if (busy_o !== 1'b1 || gcd_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL eval_cycle: busy=%b en=%b expected 1 0",
                     busy_o, gcd_enable_o);
        end
        tick();
        stub(5, 16'h0006, 1'b0, en, ok);
        checks++;
        if (!ok || en != 5 || gcd_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL enable_len: ok=%b cycles=%0d en_now=%b expected 5 0",
                     ok, en, gcd_enable_o);
        end
        tick();
        check_tx("gcd_result");
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL busy_after: busy=%b expected 0", busy_o);
        end
        send(C_NOP, 16'hffff);
        tick();
        checks++;
        if (tx_word_o !== 32'h4000_0006) begin
            failures++;
            $display("FAIL nop_read: tx=%h expected 40000006", tx_word_o);
        end
    endtask

    task automatic test_zero_operand();
        logic seen;
        send(C_LOAD_A, 16'h0000);
        send(C_LOAD_B, 16'h0015);
        sb.push_back(32'h4000_0015);
        send(C_START, 16'h0);
        seen = gcd_enable_o;
        tick();
        seen |= gcd_enable_o;
        tick();
        seen |= gcd_enable_o;
        check_tx("zero_path_tx");
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL zero_no_enable: enable seen=%b expected 0", seen);
        end
    endtask

    task automatic test_busy_reject();
        int en;
        logic ok;
        send(C_LOAD_A, 16'h0007);
        send(C_LOAD_B, 16'h000e);
        send(C_START, 16'h0);
        send(C_LOAD_A, 16'h1234);
        send(C_START, 16'h0);
        checks++;
        if (operand_a_o !== 16'h0007 || error_o !== 1'b1) begin
            failures++;
            $display("FAIL busy_reject: a=%h err=%b expected 0007 1",
                     operand_a_o, error_o);
        end
        sb.push_back(32'h6000_0007);
        stub(3, 16'h0007, 1'b0, en, ok);
        tick();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reject_complete: done not reached, en=%0d", en);
        end
        check_tx("reject_result");
        send(C_CLEAR, 16'h0);
        tick();
        checks++;
        if (tx_word_o[31:29] !== 3'b000 || error_o !== 1'b0) begin
            failures++;
            $display("FAIL reject_clear: flags=%b err=%b expected 000 0",
                     tx_word_o[31:29], error_o);
        end
    endtask

    task automatic test_clear_vs_done();
        int en;
        logic ok;
        send(C_LOAD_A, 16'h0030);
        send(C_LOAD_B, 16'h0012);
        send(C_START, 16'h0);
        sb.push_back(32'h4000_0006);
        stub(2, 16'h0006, 1'b1, en, ok);
        tick();
        check_tx("clear_vs_done");
        send(C_CLEAR, 16'h0);
        tick();
        checks++;
        if (tx_word_o[31:29] !== 3'b000) begin
            failures++;
            $display("FAIL clear_after: flags=%b expected 000", tx_word_o[31:29]);
        end
    endtask

`ifdef GCD_TIMEOUT_EN
    task automatic test_timeout();
        int en;
        logic ok;
        send(C_LOAD_A, 16'h0005);
        send(C_LOAD_B, 16'h0003);
        send(C_START, 16'h0);
        sb.push_back(32'h2000_0006);
        stub(1000, 16'h0, 1'b0, en, ok);
        checks++;
        if (en != 8 || error_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_len: cycles=%0d err=%b expected 8 1",
                     en, error_o);
        end
        check_tx("timeout_tx");
        send(C_CLEAR, 16'h0);
    endtask
`endif

    task automatic test_reset_mid_wait();
        send(C_LOAD_A, 16'h0009);
        send(C_LOAD_B, 16'h0006);
        send(C_START, 16'h0);
        send(C_START, 16'h0);
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checks++;
        if ({gcd_enable_o, busy_o, error_o} !== 3'b000 ||
            {operand_a_o, operand_b_o, tx_word_o} !== 64'h0) begin
            failures++;
            $display("FAIL reset_mid_wait: en=%b busy=%b err=%b a=%h b=%h tx=%h expected all 0",
                     gcd_enable_o, busy_o, error_o, operand_a_o, operand_b_o, tx_word_o);
        end
    endtask

    initial begin
        test_reset();
        test_gcd_run();
        test_zero_operand();
        test_busy_reject();
        test_clear_vs_done();
`ifdef GCD_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
